// File: rtl/control_unit_mc.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB and
// decodes the held instruction into datapath strobes and data-bus requests.
module control_unit_mc #(
  parameter int unsigned BUS_TIMEOUT = 0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instrCode,
  input  logic             busReady,
  output logic             PCEn,
  output logic             regFileWe,
  output logic             aluSrcMuxSel,
  output logic [3:0]       aluControl,
  output logic [2:0]       RFWDSrcMuxSel,
  output logic             branch,
  output logic             jal,
  output logic             jalr,
  output logic             busReq,
  output logic             busWe,
  output logic [2:0]       busSize,
  output logic             busErr,
  output logic             illegalInstr,
  output logic [CNT_W-1:0] instrRetired
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam int unsigned WAIT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic        TIMEOUT_EN = (BUS_TIMEOUT != 0);
  // Abort fires on the MEM cycle whose miss would bring the count to BUS_TIMEOUT.
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_s, is_b, is_jal, is_jalr;
  logic [3:0] dec_alu_ctl;
  logic       dec_alu_src;
  logic [2:0] dec_rfwd;
  logic       dec_we_exec;
  logic       dec_mem;
  logic       dec_legal;
  logic       unused_instr_bits;

  assign opcode  = instrCode[6:0];
  assign funct3  = instrCode[14:12];
  assign is_s    = (opcode == OP_S);
  assign is_b    = (opcode == OP_B);
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);
  assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  // Per-instruction decode, independent of sequencing state.
  always_comb begin
    dec_alu_ctl = 4'b0000;
    dec_alu_src = 1'b0;
    dec_rfwd    = 3'd0;
    dec_we_exec = 1'b0;
    dec_mem     = 1'b0;
    dec_legal   = 1'b1;
    case (opcode)
      OP_R: begin
        dec_alu_ctl = {instrCode[30], funct3};
        dec_we_exec = 1'b1;
      end
      OP_I: begin
        dec_alu_ctl = {(funct3 == 3'b101) & instrCode[30], funct3};
        dec_alu_src = 1'b1;
        dec_we_exec = 1'b1;
      end
      OP_L: begin
        dec_alu_src = 1'b1;
        dec_rfwd    = 3'd1;
        dec_mem     = 1'b1;
      end
      OP_S: begin
        dec_alu_src = 1'b1;
        dec_mem     = 1'b1;
      end
      OP_B: dec_alu_ctl = {1'b0, funct3};
      OP_LUI: begin
        dec_rfwd    = 3'd2;
        dec_we_exec = 1'b1;
      end
      OP_AUIPC: begin
        dec_rfwd    = 3'd3;
        dec_we_exec = 1'b1;
      end
      OP_JAL: begin
        dec_rfwd    = 3'd4;
        dec_we_exec = 1'b1;
      end
      OP_JALR: begin
        dec_alu_src = 1'b1;
        dec_rfwd    = 3'd4;
        dec_we_exec = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next state, wait counter, retire counter and strobes; all quiet while in reset.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    retired_d     = retired_q;
    PCEn          = 1'b0;
    regFileWe     = 1'b0;
    aluSrcMuxSel  = 1'b0;
    aluControl    = 4'b0000;
    RFWDSrcMuxSel = 3'd0;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    busReq        = 1'b0;
    busWe         = 1'b0;
    busSize       = 3'b000;
    busErr        = 1'b0;
    illegalInstr  = 1'b0;
    if (!reset) begin
      if (state_q != S_FETCH) begin
        aluSrcMuxSel  = dec_alu_src;
        aluControl    = dec_alu_ctl;
        RFWDSrcMuxSel = dec_rfwd;
      end
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: state_d = S_EXECUTE;
        S_EXECUTE: begin
          branch       = is_b;
          jal          = is_jal | is_jalr;
          jalr         = is_jalr;
          regFileWe    = dec_we_exec;
          illegalInstr = ~dec_legal;
          if (dec_mem) begin
            state_d = S_MEM;
          end else begin
            PCEn    = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_MEM: begin
          busReq  = 1'b1;
          busWe   = is_s;
          busSize = funct3;
          if (busReady) begin
            wait_d = '0;
            if (is_s) begin
              PCEn    = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
            busErr  = 1'b1;
            PCEn    = 1'b1;
            wait_d  = '0;
            state_d = S_FETCH;
          end else if (TIMEOUT_EN) begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        S_WB: begin
          regFileWe = 1'b1;
          PCEn      = 1'b1;
          state_d   = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
      if (PCEn) retired_d = retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign instrRetired = retired_q;

endmodule
